// File: rtl/cam_lru_array_pkg.sv
// Shared types for the LRU CAM: sizing constants, key/value/index types
// and the per-entry storage record.
package cam_types;

   localparam int camsize_p   = 8;
   localparam int key_width_p = 16;
   localparam int val_width_p = 16;
   localparam int idx_width_p = $clog2(camsize_p);

   typedef logic [key_width_p-1:0] key_t;
   typedef logic [val_width_p-1:0] val_t;
   typedef logic [idx_width_p-1:0] idx_t;

   typedef struct packed {
      logic valid;
      key_t key;
      val_t val;
   } cam_entry_t;

endpackage

// File: rtl/cam_lru_array_ages.sv
// True-LRU age permutation: age 0 is MRU, camsize_p-1 is LRU.
// A touch moves one entry to age 0 and shifts younger entries back by one.
module cam_lru_ages
   import cam_types::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic touch_i,
   input  idx_t touch_idx_i,
   output idx_t lru_idx_o
);

   idx_t age_q [camsize_p];
   idx_t touch_age;

   assign touch_age = age_q[touch_idx_i];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < camsize_p; i++)
            age_q[i] <= idx_t'(camsize_p - 1 - i);
      end else if (touch_i) begin
         for (int i = 0; i < camsize_p; i++) begin
            if (idx_t'(i) == touch_idx_i)
               age_q[i] <= '0;
            else if (age_q[i] < touch_age)
               age_q[i] <= age_q[i] + 1'b1;
         end
      end
   end

   // Exactly one entry holds the maximum age.
   always_comb begin
      lru_idx_o = '0;
      for (int i = 0; i < camsize_p; i++)
         if (age_q[i] == idx_t'(camsize_p - 1))
            lru_idx_o = idx_t'(i);
   end

endmodule

// File: rtl/cam_lru_array.sv
// Fully associative CAM, one read or write per cycle, true-LRU replacement.
// Responses and hit/evict strobes are registered one cycle after the request.
module cam_lru_array
   import cam_types::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_i,
   input  logic                   rw_n_i,
   input  logic [key_width_p-1:0] key_i,
   input  logic [val_width_p-1:0] val_i,
   output logic [val_width_p-1:0] val_o,
   output logic                   valid_o,
   output logic                   hit_o,
   output logic [idx_width_p-1:0] hit_idx_o,
   output logic                   evict_o,
   output logic [idx_width_p-1:0] evict_idx_o
);

   cam_entry_t ent_q [camsize_p];

   logic [camsize_p-1:0] match;
   logic hit;
   logic any_free;
   logic is_rd;
   logic is_wr;
   logic touch;
   idx_t hit_idx;
   idx_t free_idx;
   idx_t lru_idx;
   idx_t wr_idx;
   idx_t touch_idx;

   // Write hits reuse their entry, so at most one match bit is set.
   always_comb begin
      match   = '0;
      hit_idx = '0;
      for (int i = 0; i < camsize_p; i++) begin
         match[i] = ent_q[i].valid && (ent_q[i].key == key_i);
         if (match[i])
            hit_idx = hit_idx | idx_t'(i);
      end
      hit = |match;
   end

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = camsize_p - 1; i >= 0; i--) begin
         if (!ent_q[i].valid) begin
            any_free = 1'b1;
            free_idx = idx_t'(i);
         end
      end
   end

   always_comb begin
      is_rd     = valid_i & rw_n_i;
      is_wr     = valid_i & ~rw_n_i;
      wr_idx    = hit ? hit_idx : (any_free ? free_idx : lru_idx);
      touch     = (is_rd & hit) | is_wr;
      touch_idx = is_wr ? wr_idx : hit_idx;
   end

   cam_lru_ages u_ages (
      .clk         (clk),
      .rst_n       (rst_n),
      .touch_i     (touch),
      .touch_idx_i (touch_idx),
      .lru_idx_o   (lru_idx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < camsize_p; i++)
            ent_q[i] <= '0;
      end else if (is_wr) begin
         ent_q[wr_idx] <= '{valid: 1'b1, key: key_i, val: val_i};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         val_o       <= '0;
         valid_o     <= 1'b0;
         hit_o       <= 1'b0;
         hit_idx_o   <= '0;
         evict_o     <= 1'b0;
         evict_idx_o <= '0;
      end else begin
         valid_o     <= is_rd & hit;
         hit_o       <= valid_i & hit;
         hit_idx_o   <= hit ? hit_idx : '0;
         evict_o     <= is_wr & ~hit & ~any_free;
         evict_idx_o <= (is_wr & ~hit & ~any_free) ? lru_idx : '0;
         if (is_rd & hit)
            val_o <= ent_q[hit_idx].val;
      end
   end

endmodule

// File: tb/tb_cam_lru_array.sv
// Bench for cam_lru_array: directed scenarios then random traffic, all
// checked against a recency-queue model of the CAM.
module tb_cam_lru_array;
   import cam_types::*;

   logic clk = 1'b0;
   logic rst_n;
   logic valid_i;
   logic rw_n_i;
   key_t key_i;
   val_t val_i;
   val_t val_o;
   logic valid_o;
   logic hit_o;
   idx_t hit_idx_o;
   logic evict_o;
   idx_t evict_idx_o;

   always #5 clk = ~clk;

   cam_lru_array dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_i     (valid_i),
      .rw_n_i      (rw_n_i),
      .key_i       (key_i),
      .val_i       (val_i),
      .val_o       (val_o),
      .valid_o     (valid_o),
      .hit_o       (hit_o),
      .hit_idx_o   (hit_idx_o),
      .evict_o     (evict_o),
      .evict_idx_o (evict_idx_o)
   );

   int checks = 0;
   int errors = 0;

   logic mv   [camsize_p];
   key_t mk   [camsize_p];
   val_t mval [camsize_p];
   int   order[$];

   logic e_valid;
   logic e_hit;
   logic e_evict;
   int   e_hidx;
   int   e_eidx;
   val_t e_val;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < camsize_p; i++) mv[i] = 1'b0;
      order.delete();
      for (int i = camsize_p - 1; i >= 0; i--) order.push_back(i);
      e_val = '0;
   endtask

   task automatic touch(input int e);
      for (int p = 0; p < order.size(); p++)
         if (order[p] == e) begin
            order.delete(p);
            break;
         end
      order.push_front(e);
   endtask

   task automatic model_req(input logic v, input logic rw, input key_t k,
                            input val_t d);
      int h;
      int f;
      h = -1;
      for (int i = 0; i < camsize_p; i++)
         if (mv[i] && mk[i] == k) h = i;
      e_valid = 0; e_hit = 0; e_evict = 0; e_hidx = 0; e_eidx = 0;
      if (!v) return;
      if (rw) begin
         if (h >= 0) begin
            e_valid = 1; e_hit = 1; e_hidx = h;
            e_val = mval[h];
            touch(h);
         end
      end else if (h >= 0) begin
         mval[h] = d; e_hit = 1; e_hidx = h;
         touch(h);
      end else begin
         f = -1;
         for (int i = camsize_p - 1; i >= 0; i--)
            if (!mv[i]) f = i;
         if (f < 0) begin
            f = order[order.size() - 1];
            e_evict = 1; e_eidx = f;
         end
         mv[f] = 1; mk[f] = k; mval[f] = d;
         touch(f);
      end
   endtask

   task automatic cycle(input logic rst, input logic v, input logic rw,
                        input key_t k, input val_t d);
      rst_n = rst; valid_i = v; rw_n_i = rw; key_i = k; val_i = d;
      if (!rst) begin
         model_reset();
         e_valid = 0; e_hit = 0; e_evict = 0; e_hidx = 0; e_eidx = 0;
      end else begin
         model_req(v, rw, k, d);
      end
      @(posedge clk);
      #1;
      chk("valid_o", valid_o, e_valid);
      chk("hit_o", hit_o, e_hit);
      chk("evict_o", evict_o, e_evict);
      chk("val_o", val_o, e_val);
      if (e_hit) chk("hit_idx_o", hit_idx_o, e_hidx);
      if (e_evict) chk("evict_idx_o", evict_idx_o, e_eidx);
   endtask

   task automatic wr(input key_t k, input val_t d);
      cycle(1'b1, 1'b1, 1'b0, k, d);
   endtask

   task automatic rd(input key_t k);
      cycle(1'b1, 1'b1, 1'b1, k, '0);
   endtask

   task automatic rst_cycle();
      cycle(1'b0, 1'b1, 1'b0, 16'h5555, 16'h7777);
   endtask

   initial begin
      int pos;
      rst_n = 1'b0; valid_i = 1'b0; rw_n_i = 1'b0;
      key_i = '0; val_i = '0;
      model_reset();

      rst_cycle();
      rst_cycle();
      rd(16'h1234);
      chk("rd_after_reset_hit", hit_o, 1'b0);

      for (int k = 0; k < camsize_p; k++)
         wr(key_t'(k), val_t'(16'h100 + k));
      rd(16'h5);
      chk("fill_rd5_val", val_o, 16'h105);
      chk("fill_rd5_idx", hit_idx_o, 5);

      rd(16'h0);
      wr(16'h8, 16'h108);
      chk("evict_after_touch", evict_o, 1'b1);
      chk("evict_idx_is_1", evict_idx_o, 1);
      rd(16'h1);
      chk("evicted_key_misses", valid_o, 1'b0);

      rst_cycle();
      wr(16'hAA, 16'h1);
      pos = int'(hit_idx_o);
      wr(16'hAA, 16'h2);
      chk("ww_same_key_hit", hit_o, 1'b1);
      chk("ww_same_idx", hit_idx_o, 0);
      rd(16'hAA);
      chk("ww_read_new", val_o, 16'h2);
      wr(16'hBB, 16'h3);
      rd(16'hBB);
      chk("wr_read_val", val_o, 16'h3);

      rst_cycle();
      for (int k = 0; k < camsize_p; k++)
         wr(key_t'(16'h10 + k), val_t'(k));
      for (int k = 0; k < camsize_p; k++) begin
         wr(key_t'(16'h20 + k), val_t'(k + 1));
         chk("sweep_evict", evict_o, 1'b1);
         chk("sweep_idx", evict_idx_o, k);
      end
      for (int k = 0; k < camsize_p / 2; k++)
         wr(key_t'(16'h30 + k), val_t'(k));
      rst_cycle();
      wr(16'h99, 16'h9);
      chk("post_reset_no_evict", evict_o, 1'b0);
      rd(16'h99);
      chk("post_reset_entry0", hit_idx_o, 0);
      rd(16'h30);
      chk("post_reset_old_miss", hit_o, 1'b0);

      cycle(1'b1, 1'b0, 1'b1, 16'h99, '0);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) < 2)
            rst_cycle();
         else
            cycle(1'b1, ($urandom_range(0, 99) < 85),
                  1'($urandom_range(0, 1)),
                  key_t'($urandom_range(0, 11)),
                  val_t'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
